// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing constants and types for the timing generator and overlays.
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END = VGA_VS_START + VGA_V_SYNC;
  localparam logic [23:0] BLACK = 24'h000000;
  typedef logic [9:0] cnt_t;
endpackage

// File: rtl/pix_tick_gen.sv
// pix_tick_gen: divides clk down to a one-clock pixel strobe every CLK_DIV clocks.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] div_cnt_q, div_cnt_d;
  logic last;
  always_comb begin
    last = div_cnt_q == W'(CLK_DIV - 1);
    pix_tick = rst_n && last;
    div_cnt_d = last ? '0 : div_cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_cnt_q <= '0;
    else div_cnt_q <= div_cnt_d;
endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster counters plus registered HSYNC/VSYNC/RGB output stage,
// all advancing on the divided pixel tick so syncs and colour stay aligned.
module vga_timing import vga_pkg::*; #(
  parameter int CLK_DIV = 4,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  hcounter,
  output logic [9:0]  vcounter,
  output logic        active,
  output logic        pix_tick,
  output logic        frame_start,
  input  logic        pix_visible,
  input  logic [23:0] pix_rgb,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [23:0] vga_rgb
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HSS = H_ACTIVE + H_FP;
  localparam int VSS = V_ACTIVE + V_FP;
  if (HT > 1024 || VT > 1024) begin : g_bad_timing
    $error("vga_timing: line or frame total exceeds 10-bit counter range");
  end
  cnt_t h_q, h_d, v_q, v_d;
  logic hs_q, hs_d, vs_q, vs_d, h_wrap, v_wrap;
  logic [23:0] rgb_q, rgb_d;
  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .pix_tick(pix_tick)
  );
  always_comb begin
    h_wrap = h_q == 10'(HT - 1);
    v_wrap = v_q == 10'(VT - 1);
    active = h_q < 10'(H_ACTIVE) && v_q < 10'(V_ACTIVE);
    h_d = !pix_tick ? h_q : h_wrap ? '0 : h_q + 10'd1;
    v_d = !(pix_tick && h_wrap) ? v_q : v_wrap ? '0 : v_q + 10'd1;
    hs_d = pix_tick ? !(h_q >= 10'(HSS) && h_q < 10'(HSS + H_SYNC)) : hs_q;
    vs_d = pix_tick ? !(v_q >= 10'(VSS) && v_q < 10'(VSS + V_SYNC)) : vs_q;
    rgb_d = !pix_tick ? rgb_q : !active ? BLACK : pix_visible ? pix_rgb : BG_COLOR;
    frame_start = pix_tick && h_wrap && v_wrap;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      rgb_q <= BLACK;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      rgb_q <= rgb_d;
    end
  assign hcounter = h_q;
  assign vcounter = v_q;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_rgb = rgb_q;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: randomized overlay stimulus against a tick-count based raster model.
module tb_vga_timing;
  localparam int D = 4;
  localparam int HA = 16, HF = 4, HS = 6, HB = 5;
  localparam int VA = 10, VF = 2, VS = 3, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam logic [23:0] BG = 24'h123456;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [9:0] hcounter, vcounter;
  logic active, pix_tick, frame_start, pix_visible, vga_hs, vga_vs;
  logic [23:0] pix_rgb, vga_rgb;
  int checks = 0, fails = 0, k = 0;
  logic exp_hs = 1'b1, exp_vs = 1'b1;
  logic [23:0] exp_rgb = 24'h0;
  vga_timing #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hcounter(hcounter), .vcounter(vcounter),
    .active(active), .pix_tick(pix_tick), .frame_start(frame_start),
    .pix_visible(pix_visible), .pix_rgb(pix_rgb),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (k=%0d)", tag, got, exp, k);
    end
  endtask
  // Position follows from the number of ticks since reset; outputs lag one tick.
  task automatic compare_all();
    int p, h, v;
    bit tk;
    p = (k / D) % FR;
    h = p % HT;
    v = p / HT;
    tk = rst_n && (k % D == D - 1);
    check("hcounter", 32'(hcounter), 32'(h));
    check("vcounter", 32'(vcounter), 32'(v));
    check("active", 32'(active), 32'(h < HA && v < VA));
    check("pix_tick", 32'(pix_tick), 32'(tk));
    check("frame_start", 32'(frame_start), 32'(tk && p == FR - 1));
    check("vga_hs", 32'(vga_hs), 32'(exp_hs));
    check("vga_vs", 32'(vga_vs), 32'(exp_vs));
    check("vga_rgb", 32'(vga_rgb), 32'(exp_rgb));
  endtask
  task automatic step();
    int p, h, v;
    @(negedge clk);
    compare_all();
    p = (k / D) % FR;
    h = p % HT;
    v = p / HT;
    pix_visible = ($urandom_range(3) == 0) || (h == 5 && v == 3);
    pix_rgb = 24'($urandom);
    if (rst_n && (k % D == D - 1)) begin
      exp_hs = !(h >= HA + HF && h < HA + HF + HS);
      exp_vs = !(v >= VA + VF && v < VA + VF + VS);
      exp_rgb = (h < HA && v < VA) ? (pix_visible ? pix_rgb : BG) : 24'h0;
    end
    @(posedge clk);
    if (rst_n) k++;
  endtask
  task automatic apply_reset(int n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    k = 0;
    exp_hs = 1'b1;
    exp_vs = 1'b1;
    exp_rgb = 24'h0;
    #1 compare_all();
    repeat (n) step();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask
  initial begin
    pix_visible = 1'b0;
    pix_rgb = 24'h0;
    apply_reset(3);
    repeat (2 * FR * D + 300) step();
    apply_reset($urandom_range(4, 1));
    repeat (FR * D + 100) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
